// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path: FSM encoding, protocol constants
// and a byte-pick helper for the address filters.
package udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HEAD,
        ST_IP_HEAD,
        ST_UDP_HEAD,
        ST_RX_DATA,
        ST_RX_END
    } rx_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam int          ETH_HEAD_LEN  = 14;
    localparam int          UDP_HEAD_LEN  = 8;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // Byte idx of a big-endian field nbytes wide held in the low bytes of word; 0 when out of range.
    function automatic logic [7:0] be_byte(input logic [47:0] word, input int unsigned nbytes,
                                           input int unsigned idx);
        logic [7:0] b;
        b = 8'h00;
        for (int unsigned k = 0; k < 6; k++) begin
            if (idx < nbytes && k == nbytes - 1 - idx)
                b = word[8*k +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/crc32_d8_rx.sv
// Byte-wide Ethernet CRC-32 (poly 04C11DB7, preset all-ones, bits fed LSB first).
// A good frame including its FCS leaves CRC32_RESIDUE in the register.
module crc32_d8_rx
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    logic [31:0] crc_nx;

    always_comb begin
        logic fb;
        crc_nx = crc;
        for (int i = 0; i < 8; i++) begin
            fb     = crc_nx[31] ^ data[i];
            crc_nx = {crc_nx[30:0], 1'b0} ^ ({32{fb}} & CRC32_POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= 32'hFFFF_FFFF;
        else if (clr)
            crc <= 32'hFFFF_FFFF;
        else if (en)
            crc <= crc_nx;
    end

endmodule

// File: rtl/udp_rx.sv
// GMII UDP receiver: strips preamble/Ethernet/IPv4/UDP headers, filters on board MAC/IP,
// streams the payload. Define UDP_RX_CRC_CHECK_EN to gate rec_pkt_done on the FCS.
//
// state       | meaning
// ST_IDLE     | waiting for first 0x55 of a preamble
// ST_PREAMBLE | counting 0x55 bytes, expecting SFD 0xD5
// ST_ETH_HEAD | destination MAC and ethertype filter
// ST_IP_HEAD  | version/IHL, protocol, destination IP; options skipped
// ST_UDP_HEAD | UDP length latched, payload size derived
// ST_RX_DATA  | payload bytes strobed out
// ST_RX_END   | rest of frame ignored until dv falls; done pulse if accepted
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic [15:0] rec_byte_num,
    output logic        rec_pkt_done,
    output logic        rec_err
);

    rx_state_t   state, state_nx;
    logic [7:0]  cnt;
    logic [3:0]  ihl;
    logic        uni_ok, bc_ok;
    logic [15:0] udp_len;
    logic [15:0] data_cnt;
    logic        accepted;

    logic        en_nx, err_nx, done_nx, accept_set;
    logic [7:0]  mac_byte, ip_byte;
    logic        uni_hit, bc_hit, mac_match;
    logic        crc_ok;

    assign mac_byte  = be_byte(BOARD_MAC, 6, 32'(cnt));
    assign ip_byte   = be_byte({16'h0000, BOARD_IP}, 4, 32'(cnt - 8'd16));
    // A MAC prefix stays alive only while every byte so far has matched it.
    assign uni_hit   = (cnt == 8'd0 || uni_ok) && gmii_rxd == mac_byte;
    assign bc_hit    = (cnt == 8'd0 || bc_ok) && gmii_rxd == 8'hff;
    assign mac_match = uni_hit || bc_hit;

`ifdef UDP_RX_CRC_CHECK_EN
    logic [31:0] crc;
    logic        crc_en;

    assign crc_en = gmii_rx_dv &&
                    (state inside {ST_ETH_HEAD, ST_IP_HEAD, ST_UDP_HEAD, ST_RX_DATA, ST_RX_END});

    crc32_d8_rx u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_PREAMBLE),
        .en    (crc_en),
        .data  (gmii_rxd),
        .crc   (crc)
    );

    assign crc_ok = (crc == CRC32_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        en_nx      = 1'b0;
        err_nx     = 1'b0;
        done_nx    = 1'b0;
        accept_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gmii_rx_dv && gmii_rxd == 8'h55)
                    state_nx = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv)
                    state_nx = ST_IDLE;
                else if (gmii_rxd == 8'hd5 && cnt >= 8'd5)
                    state_nx = ST_ETH_HEAD;
                else if (gmii_rxd != 8'h55)
                    state_nx = ST_RX_END;
            end
            ST_ETH_HEAD: begin
                if (!gmii_rx_dv) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt < 8'd6 && !mac_match)
                    state_nx = ST_RX_END;
                else if (cnt == 8'd12 && gmii_rxd != ETH_TYPE_IPV4[15:8])
                    state_nx = ST_RX_END;
                else if (cnt == 8'(ETH_HEAD_LEN - 1))
                    state_nx = (gmii_rxd == ETH_TYPE_IPV4[7:0]) ? ST_IP_HEAD : ST_RX_END;
            end
            ST_IP_HEAD: begin
                if (!gmii_rx_dv) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == 8'd0) begin
                    if (gmii_rxd[7:4] != 4'd4)
                        state_nx = ST_RX_END;
                    else if (gmii_rxd[3:0] < 4'd5) begin
                        err_nx   = 1'b1;
                        state_nx = ST_RX_END;
                    end
                end else if (cnt == 8'd9 && gmii_rxd != IP_PROTO_UDP)
                    state_nx = ST_RX_END;
                else if (cnt >= 8'd16 && cnt <= 8'd19 && gmii_rxd != ip_byte)
                    state_nx = ST_RX_END;
                else if (cnt == {2'b00, ihl, 2'b00} - 8'd1)
                    state_nx = ST_UDP_HEAD;
            end
            ST_UDP_HEAD: begin
                if (!gmii_rx_dv) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == 8'd5 && {udp_len[15:8], gmii_rxd} < 16'(UDP_HEAD_LEN)) begin
                    err_nx   = 1'b1;
                    state_nx = ST_RX_END;
                end else if (cnt == 8'(UDP_HEAD_LEN - 1)) begin
                    if (udp_len == 16'(UDP_HEAD_LEN)) begin
                        accept_set = 1'b1;
                        state_nx   = ST_RX_END;
                    end else
                        state_nx = ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (!gmii_rx_dv) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    en_nx = 1'b1;
                    if (data_cnt == rec_byte_num - 16'd1) begin
                        accept_set = 1'b1;
                        state_nx   = ST_RX_END;
                    end
                end
            end
            ST_RX_END: begin
                if (!gmii_rx_dv) begin
                    state_nx = ST_IDLE;
                    if (accepted) begin
                        done_nx = crc_ok;
                        err_nx  = !crc_ok;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 8'd0;
            ihl          <= 4'd0;
            uni_ok       <= 1'b0;
            bc_ok        <= 1'b0;
            udp_len      <= 16'd0;
            data_cnt     <= 16'd0;
            accepted     <= 1'b0;
            rec_en       <= 1'b0;
            rec_data     <= 8'd0;
            rec_byte_num <= 16'd0;
            rec_pkt_done <= 1'b0;
            rec_err      <= 1'b0;
        end else begin
            if (state_nx != state)
                cnt <= 8'd0;
            else if (gmii_rx_dv && cnt != 8'hff)
                cnt <= cnt + 8'd1;

            if (state == ST_ETH_HEAD && gmii_rx_dv && cnt < 8'd6) begin
                uni_ok <= uni_hit;
                bc_ok  <= bc_hit;
            end

            if (state == ST_IP_HEAD && gmii_rx_dv && cnt == 8'd0)
                ihl <= gmii_rxd[3:0];

            if (state == ST_UDP_HEAD && gmii_rx_dv) begin
                if (cnt == 8'd4)
                    udp_len[15:8] <= gmii_rxd;
                if (cnt == 8'd5)
                    udp_len[7:0] <= gmii_rxd;
                if (cnt == 8'(UDP_HEAD_LEN - 1))
                    rec_byte_num <= udp_len - 16'(UDP_HEAD_LEN);
            end

            if (state != ST_RX_DATA)
                data_cnt <= 16'd0;
            else if (gmii_rx_dv)
                data_cnt <= data_cnt + 16'd1;

            if (state_nx == ST_IDLE)
                accepted <= 1'b0;
            else if (accept_set)
                accepted <= 1'b1;

            rec_en       <= en_nx;
            rec_pkt_done <= done_nx;
            rec_err      <= err_nx;
            if (en_nx)
                rec_data <= gmii_rxd;
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Scoreboard bench for udp_rx: frames are built from header fields, a byte-walk reference
// model queues the expected payload/done/err events, and a monitor pops them as the DUT emits.
module tb_udp_rx;

    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam logic [31:0] IP_OTHER = {8'd192, 8'd168, 8'd1, 8'd99};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic [15:0] rec_byte_num;
    logic        rec_pkt_done;
    logic        rec_err;

    always #4 clk = ~clk;

    udp_rx #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_byte_num (rec_byte_num),
        .rec_pkt_done (rec_pkt_done),
        .rec_err      (rec_err)
    );

    // kind: 0 payload byte, 1 packet done, 2 error
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [15:0] num;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frm[$];
    logic [7:0] pay[$];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] d, input logic [15:0] n);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.num  = n;
        exp_q.push_back(e);
    endtask

    // Reflected CRC-32 over frm[from..end]
    function automatic logic [31:0] crc_ref(input int from);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < frm.size(); i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [3:0] ver,
                         input logic [3:0] ihl, input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] ulen, input bit bad_fcs);
        int          hb;
        logic [15:0] tlen;
        logic [31:0] fcs;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hd5);
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
        repeat (6) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        hb   = (ihl < 4'd5) ? 20 : int'(ihl) * 4;
        tlen = 16'(hb + 8 + pay.size());
        for (int i = 0; i < hb; i++) begin
            case (i)
                0:  frm.push_back({ver, ihl});
                2:  frm.push_back(tlen[15:8]);
                3:  frm.push_back(tlen[7:0]);
                8:  frm.push_back(8'd64);
                9:  frm.push_back(proto);
                16: frm.push_back(dip[31:24]);
                17: frm.push_back(dip[23:16]);
                18: frm.push_back(dip[15:8]);
                19: frm.push_back(dip[7:0]);
                default: frm.push_back(8'($urandom));
            endcase
        end
        repeat (4) frm.push_back(8'($urandom));
        frm.push_back(ulen[15:8]);
        frm.push_back(ulen[7:0]);
        frm.push_back(8'h00);
        frm.push_back(8'h00);
        foreach (pay[i]) frm.push_back(pay[i]);
        while (frm.size() - 8 < 60) frm.push_back(8'h00);
        fcs = ~crc_ref(8);
        for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
        if (bad_fcs) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    endtask

    task automatic truncate(input int cut);
        while (frm.size() > cut) void'(frm.pop_back());
    endtask

    // Walks the frame byte by byte as a receiver would and queues what it should report.
    task automatic model();
        int         n, p, ihl, ulen, plen;
        logic [7:0] b;
        bit         uni, bc;
        n   = frm.size();
        p   = 8;
        uni = 1'b1;
        bc  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (p + i >= n) begin push_ev(2, 0, 0); return; end
            b = frm[p+i];
            if (i < 6) begin
                uni = uni && (b == MAC[8*(5-i) +: 8]);
                bc  = bc && (b == 8'hff);
                if (!uni && !bc) return;
            end
            if (i == 12 && b != 8'h08) return;
            if (i == 13 && b != 8'h00) return;
        end
        p = 22;
        if (p >= n) begin push_ev(2, 0, 0); return; end
        b = frm[p];
        if (b[7:4] != 4'd4) return;
        ihl = int'(b[3:0]);
        if (ihl < 5) begin push_ev(2, 0, 0); return; end
        for (int i = 1; i < ihl * 4; i++) begin
            if (p + i >= n) begin push_ev(2, 0, 0); return; end
            b = frm[p+i];
            if (i == 9 && b != 8'd17) return;
            if (i >= 16 && i <= 19 && b != IP[8*(19-i) +: 8]) return;
        end
        p = p + ihl * 4;
        ulen = 0;
        for (int i = 0; i < 8; i++) begin
            if (p + i >= n) begin push_ev(2, 0, 0); return; end
            if (i == 5) begin
                ulen = int'({frm[p+4], frm[p+5]});
                if (ulen < 8) begin push_ev(2, 0, 0); return; end
            end
        end
        plen = ulen - 8;
        p    = p + 8;
        for (int j = 0; j < plen; j++) begin
            if (p + j >= n) begin push_ev(2, 0, 0); return; end
            push_ev(0, frm[p+j], 16'(plen));
        end
`ifdef UDP_RX_CRC_CHECK_EN
        if (crc_ref(8) != 32'hDEBB_20E3) begin push_ev(2, 0, 0); return; end
`endif
        push_ev(1, 0, 16'(plen));
    endtask

    task automatic send(input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic set_pay(input int n, input bit ramp);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(ramp ? 8'(i) : 8'($urandom));
    endtask

    task automatic set_deadbeef();
        pay.delete();
        pay.push_back(8'hde);
        pay.push_back(8'had);
        pay.push_back(8'hbe);
        pay.push_back(8'hef);
    endtask

    task automatic got(input int kind, input logic [7:0] d, input logic [15:0] n);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got kind %0d want no output", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        if (kind == 0 && e.kind == 0) chk("rec_data", {24'h0, d}, {24'h0, e.data});
        if (kind != 2 && e.kind == kind) chk("rec_byte_num", {16'h0, n}, {16'h0, e.num});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rec_en) got(0, rec_data, rec_byte_num);
            if (rec_pkt_done) begin
                chk("done_with_en", {31'h0, rec_en}, 32'h0);
                got(1, 8'h00, rec_byte_num);
            end
            if (rec_err) got(2, 8'h00, rec_byte_num);
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rec_en"}, {31'h0, rec_en}, 32'h0);
        chk({tag, "_rec_data"}, {24'h0, rec_data}, 32'h0);
        chk({tag, "_rec_byte_num"}, {16'h0, rec_byte_num}, 32'h0);
        chk({tag, "_rec_pkt_done"}, {31'h0, rec_pkt_done}, 32'h0);
        chk({tag, "_rec_err"}, {31'h0, rec_err}, 32'h0);
    endtask

    task automatic good_frame(input logic [47:0] dmac, input logic [31:0] dip, input bit bad_fcs,
                              input int gap);
        build(dmac, 16'h0800, 4'd4, 4'd5, 8'd17, dip, 16'(pay.size() + 8), bad_fcs);
        model();
        send(gap);
    endtask

    initial begin
        logic [47:0] dmac;
        logic [15:0] etype, ulen;
        logic [3:0]  ver, ihl;
        logic [7:0]  proto;
        logic [31:0] dip;
        int          r, plen;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        set_deadbeef();
        good_frame(MAC, IP, 1'b0, 12);
        good_frame(48'hff_ff_ff_ff_ff_ff, IP, 1'b0, 12);
        good_frame(MAC, IP_OTHER, 1'b0, 12);

        set_pay(18, 1'b1);
        build(MAC, 16'h0800, 4'd4, 4'd6, 8'd17, IP, 16'd26, 1'b0);
        model();
        send(12);

        set_deadbeef();
        build(MAC, 16'h0800, 4'd4, 4'd5, 8'd17, IP, 16'd12, 1'b0);
        truncate(52);
        model();
        send(12);
        good_frame(MAC, IP, 1'b0, 12);
        good_frame(MAC, IP, 1'b1, 12);

        pay.delete();
        good_frame(MAC, IP, 1'b0, 12);
        set_deadbeef();
        build(MAC, 16'h0800, 4'd4, 4'd5, 8'd17, IP, 16'd7, 1'b0);
        model();
        send(12);

        set_pay(6, 1'b0);
        good_frame(MAC, IP, 1'b0, 12);
        set_pay(9, 1'b0);
        good_frame(48'hff_ff_ff_ff_ff_ff, IP, 1'b0, 12);

        // Reset in the middle of the IP header: nothing may be reported for this frame.
        set_deadbeef();
        build(MAC, 16'h0800, 4'd4, 4'd5, 8'd17, IP, 16'd12, 1'b0);
        truncate(30);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        @(negedge clk);
        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        @(negedge clk);
        chk_outputs_zero("midreset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        good_frame(MAC, IP, 1'b0, 12);

        for (int f = 0; f < 40; f++) begin
            r    = $urandom_range(0, 7);
            dmac = (r < 5) ? MAC : (r < 7) ? 48'hff_ff_ff_ff_ff_ff
                                           : (MAC ^ (48'h1 << $urandom_range(0, 47)));
            etype = ($urandom_range(0, 15) == 0) ? 16'h86dd : 16'h0800;
            ver   = ($urandom_range(0, 15) == 0) ? 4'd6 : 4'd4;
            ihl   = ($urandom_range(0, 15) == 0) ? 4'd3 : 4'($urandom_range(5, 7));
            proto = ($urandom_range(0, 15) == 0) ? 8'd6 : 8'd17;
            dip   = ($urandom_range(0, 7) == 0) ? IP_OTHER : IP;
            plen  = $urandom_range(0, 40);
            set_pay(plen, 1'b0);
            ulen  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 7)) : 16'(plen + 8);
            build(dmac, etype, ver, ihl, proto, dip, ulen, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) truncate($urandom_range(9, frm.size() - 1));
            model();
            send($urandom_range(1, 12));
        end

        repeat (10) @(negedge clk);
        chk("pending_events", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
# udp_rx

GMII-side UDP frame receiver; the receive counterpart of the board's UDP transmit path. Sits behind the RGMII-to-GMII converter in the `gmii_rx_clk` domain. Strips preamble, Ethernet, IPv4 and UDP headers. Filters on the board MAC and IP, then streams the UDP payload bytes out with a length and an end-of-packet pulse.

## Interface
Parameters:
- `BOARD_MAC`, default `48'h00_11_22_33_44_55`: accepted destination MAC. `48'hff_ff_ff_ff_ff_ff` is also always accepted.
- `BOARD_IP`, default `{8'd192,8'd168,8'd1,8'd123}`: accepted destination IPv4 address.

Ports:
- `clk` in 1: receive clock (GMII rx clock). One clock only.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `gmii_rx_dv` in 1: GMII receive data valid.
- `gmii_rxd` in 8: GMII receive byte.
- `rec_en` out 1: one-cycle strobe; `rec_data` holds a payload byte.
- `rec_data` out 8: payload byte.
- `rec_byte_num` out 16: payload length of the current packet (UDP length − 8).
- `rec_pkt_done` out 1: one-cycle pulse; packet received and accepted.
- `rec_err` out 1: one-cycle pulse; malformed or truncated frame aborted.

## Operation
FSM states: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END. An 8-bit `cnt` byte counter is cleared on every state change.

- **IDLE**: `dv=1` and byte `0x55` → PREAMBLE.
- **PREAMBLE**: counts `0x55` bytes.
  - `0xD5` after ≥6 `0x55` bytes → ETH_HEAD.
  - Any other byte → RX_END (silent drop).
- **ETH_HEAD**: 14 bytes.
  - Bytes 0–5 are the destination MAC; must equal `BOARD_MAC` or all-ones.
  - Bytes 12–13 are the ethertype; must be `0x0800`.
  - Mismatch → RX_END, silent drop.
- **IP_HEAD**:
  - Byte 0: version must be 4. IHL is latched; `IHL < 5` → error.
  - Byte 9: protocol must be 17.
  - Bytes 16–19: destination IP must equal `BOARD_IP`.
  - Options are skipped until `cnt == IHL*4−1`, then → UDP_HEAD.
  - Header checksum is ignored.
- **UDP_HEAD**: 8 bytes. Bytes 4–5 are the UDP length.
  - Length < 8 → error.
  - Otherwise latch `rec_byte_num = len−8` at byte 7.
  - If `rec_byte_num == 0` → RX_END; else → RX_DATA.
- **RX_DATA**: each byte gives `rec_en=1` with `rec_data=byte`. After byte `rec_byte_num−1` → RX_END. Padding and FCS are never output.
- **RX_END**: waits for `dv=0`, then → IDLE.
  - If the packet was accepted (passed filters, reached RX_END from UDP_HEAD/RX_DATA), `rec_pkt_done` pulses in the cycle of the transition.
- **Error / truncation**: `dv` falling in any state after PREAMBLE and before RX_END → `rec_err` pulse and return to IDLE. No `rec_pkt_done` for that frame. Bytes already strobed stay delivered.
- **Silent drops**: never pulse `rec_err` or `rec_pkt_done`.
- **Frame restart**: `dv` must be low for ≥1 cycle between frames. A frame started while in RX_END is ignored until `dv` falls.

## Timing
- All outputs are registered. Reset value of every output is 0. Reset mid-frame returns to IDLE with no pulses.
- `rec_en`/`rec_data` appear 1 cycle after the byte is on `gmii_rxd`.
- `rec_byte_num` is valid from the first `rec_en` (or from `rec_pkt_done` for empty packets) until the next UDP_HEAD byte 7. It is held otherwise.
- `rec_pkt_done` fires 1 cycle after the first `dv=0` sample following the payload. It is never coincident with `rec_en`.
- No backpressure: the consumer must accept one byte per clock.

## Configuration
- `UDP_RX_CRC_CHECK_EN` defined:
  - A CRC-32 runs over all bytes from destination MAC through FCS; the residue is checked at frame end.
  - Residue ≠ `32'hC704DD7B` → `rec_err` instead of `rec_pkt_done`.
  - Payload bytes are still strobed before the check completes.
- Undefined: no CRC logic is instantiated, and `rec_pkt_done` depends only on the header filters and length.

## Structure
- Shared package `udp_pkg`:
  - state encoding;
  - `ETH_TYPE_IPV4 = 16'h0800`;
  - `IP_PROTO_UDP = 8'd17`;
  - `ETH_HEAD_LEN = 14`;
  - `UDP_HEAD_LEN = 8`;
  - `CRC32_RESIDUE = 32'hC704DD7B`.
- Sub-module `crc32_d8_rx`: byte-wide CRC-32 with `en`/`clr`. Instantiated only under `UDP_RX_CRC_CHECK_EN`.

## Test plan
- **Valid unicast**: frame to `BOARD_MAC`/`BOARD_IP` with UDP len 12, payload `DE AD BE EF`, good FCS → 4 `rec_en` strobes with those bytes, `rec_byte_num=4`, one `rec_pkt_done`, no `rec_err`.
- **Broadcast MAC**: same frame, destination `ff:ff:ff:ff:ff:ff` → accepted identically. With `BOARD_IP` changed to 192.168.1.99 instead → no strobes, no pulses.
- **IP options**: IHL=6 (4 option bytes), 18-byte payload `0x00..0x11`, frame padded to 64 bytes → 18 strobes, padding/FCS not output, `rec_pkt_done`.
- **Truncation**: `dv` drops after 2 of 4 payload bytes → 2 strobes, one `rec_err`. The next valid frame is received normally.
- **Bad FCS** (macro defined): flip one FCS bit → payload strobed, `rec_err`, no `rec_pkt_done`. Macro undefined → `rec_pkt_done`.
- **Edge cases**:
  - UDP len 8 → `rec_pkt_done` with `rec_byte_num=0`, no strobes.
  - UDP len 7 → `rec_err`.
  - Back-to-back frames with 12-cycle IPG → both done.
